// File: rtl/control_pipeline.sv
// Execute/Memory/Writeback control-word pipeline for the pipelined RISC-V core.
// Also resolves branch/jump PC-select in Execute from the E-stage word and ZeroE.
module control_pipeline #(
   parameter int ALU_CTRL_W   = 3,
   parameter int RESULT_SRC_W = 2
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    FlushE,
   input  logic                    RegWriteD,
   input  logic [RESULT_SRC_W-1:0] ResultSrcD,
   input  logic                    MemWriteD,
   input  logic                    JumpD,
   input  logic                    JalrD,
   input  logic                    BeqD,
   input  logic                    BneD,
   input  logic [ALU_CTRL_W-1:0]   ALUControlD,
   input  logic                    ALUSrcD,
   input  logic [4:0]              RdD,
   input  logic                    ZeroE,
   output logic [ALU_CTRL_W-1:0]   ALUControlE,
   output logic                    ALUSrcE,
   output logic [1:0]              PCSrcE,
   output logic                    LoadE,
   output logic [4:0]              RdE,
   output logic                    RegWriteM,
   output logic                    MemWriteM,
   output logic [RESULT_SRC_W-1:0] ResultSrcM,
   output logic [4:0]              RdM,
   output logic                    RegWriteW,
   output logic [RESULT_SRC_W-1:0] ResultSrcW,
   output logic [4:0]              RdW
);

   logic                    RegWriteE;
   logic [RESULT_SRC_W-1:0] ResultSrcE;
   logic                    MemWriteE;
   logic                    JumpE;
   logic                    JalrE;
   logic                    BeqE;
   logic                    BneE;

   // Reset and flush both load a bubble into E; only reset also clears M and W.
   always_ff @(posedge clk) begin
      if (rst || FlushE) begin
         RegWriteE   <= 1'b0;
         ResultSrcE  <= '0;
         MemWriteE   <= 1'b0;
         JumpE       <= 1'b0;
         JalrE       <= 1'b0;
         BeqE        <= 1'b0;
         BneE        <= 1'b0;
         ALUControlE <= '0;
         ALUSrcE     <= 1'b0;
         RdE         <= '0;
      end else begin
         RegWriteE   <= RegWriteD;
         ResultSrcE  <= ResultSrcD;
         MemWriteE   <= MemWriteD;
         JumpE       <= JumpD;
         JalrE       <= JalrD;
         BeqE        <= BeqD;
         BneE        <= BneD;
         ALUControlE <= ALUControlD;
         ALUSrcE     <= ALUSrcD;
         RdE         <= RdD;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         RegWriteM  <= 1'b0;
         MemWriteM  <= 1'b0;
         ResultSrcM <= '0;
         RdM        <= '0;
      end else begin
         RegWriteM  <= RegWriteE;
         MemWriteM  <= MemWriteE;
         ResultSrcM <= ResultSrcE;
         RdM        <= RdE;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         RegWriteW  <= 1'b0;
         ResultSrcW <= '0;
         RdW        <= '0;
      end else begin
         RegWriteW  <= RegWriteM;
         ResultSrcW <= ResultSrcM;
         RdW        <= RdM;
      end
   end

   // jalr wins over jal/branches: its target comes from the ALU, not PC+imm.
   always_comb begin
      PCSrcE = 2'b00;
      if (JalrE)
         PCSrcE = 2'b10;
      else if (JumpE || (BeqE && ZeroE) || (BneE && !ZeroE))
         PCSrcE = 2'b01;
   end

   always_comb begin
      LoadE = (ResultSrcE == RESULT_SRC_W'(1));
   end

endmodule

// File: doc/control_pipeline.md
Name: control_pipeline

Overview:
- Carries the decode-stage control word through the Execute, Memory and Writeback pipeline registers of the pipelined RISC-V core.
- Sits directly downstream of the decode controller and consumes its D-stage outputs.
- Resolves branches and jumps in Execute, producing the PC-select for the fetch stage.
- Exposes per-stage control and destination-register bits to the datapath and the hazard unit.

Parameters:
- ALU_CTRL_W, 3, width of the ALU control field.
- RESULT_SRC_W, 2, width of the writeback result-source select.

Ports:
- clk  input  1  core clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- FlushE  input  1  hazard-unit request to turn the E-stage register into a bubble.
- RegWriteD  input  1  register-file write enable from decode.
- ResultSrcD  input  RESULT_SRC_W  writeback select from decode (00 ALU, 01 memory, 10 PC+4).
- MemWriteD  input  1  data-memory write from decode.
- JumpD  input  1  jal from decode.
- JalrD  input  1  jalr from decode.
- BeqD  input  1  beq from decode.
- BneD  input  1  bne from decode.
- ALUControlD  input  ALU_CTRL_W  ALU function from decode.
- ALUSrcD  input  1  ALU B-operand select from decode.
- RdD  input  5  destination register from decode.
- ZeroE  input  1  ALU zero flag of the instruction currently in E.
- ALUControlE  output  ALU_CTRL_W  E-stage ALU function.
- ALUSrcE  output  1  E-stage ALU B select.
- PCSrcE  output  2  next-PC select: 00 PC+4, 01 PC+imm (branch taken or jal), 10 ALU result (jalr).
- LoadE  output  1  ResultSrcE==01; drives load-use detection.
- RdE  output  5  E-stage destination register.
- RegWriteM  output  1  M-stage register write.
- MemWriteM  output  1  M-stage memory write.
- ResultSrcM  output  RESULT_SRC_W  M-stage result select.
- RdM  output  5  M-stage destination register.
- RegWriteW  output  1  W-stage register write.
- ResultSrcW  output  RESULT_SRC_W  W-stage result select.
- RdW  output  5  W-stage destination register.

Behaviour:
- State: three registers.
  - E holds the full D control word plus RdD.
  - M holds RegWrite, MemWrite, ResultSrc and Rd.
  - W holds RegWrite, ResultSrc and Rd.
- Latency: a D value is visible on E outputs 1 cycle after its capture edge, on M outputs after 2 cycles, and on W outputs after 3 cycles.
- No stall input: E, M and W advance every cycle.
- Reset: when rst=1 at an edge, all E, M and W fields become 0. After reset:
  - every output is 0, PCSrcE=00, LoadE=0.
  - Reset mid-operation discards all in-flight instructions in the same edge.
- Flush: when FlushE=1 (and rst=0), E captures all-zero fields (a bubble) instead of the D inputs.
  - M and W still capture the previous E and M contents, so the instruction already in E proceeds normally.
  - Priority: rst > FlushE > normal capture.
- PCSrcE (combinational from E registers and ZeroE):
  - 10 if JalrE.
  - else 01 if JumpE | (BeqE & ZeroE) | (BneE & ~ZeroE).
  - else 00.
  - JalrE with JumpE also set: the result is 10.
  - A bubble in E always yields 00, whatever ZeroE is.
- LoadE = (ResultSrcE == 01). It is 0 during a bubble.
- Dropped fields: branch/jump/ALU fields are not carried beyond E, and MemWrite is not carried beyond M.
- Simultaneous FlushE with a taken branch in E: PCSrcE still reflects the branch during that cycle. The flush affects only the next E contents.
- No X propagation: all registers are explicitly reset, and outputs are never derived from uninitialised state.

Test Plan:
- Reset: assert rst for 2 cycles with all D inputs at 1 -> every output 0, PCSrcE=00.
- Pipeline flow: D word {RegWrite=1, ResultSrc=01, MemWrite=0, ALUControl=010, ALUSrc=1, Rd=5} for one cycle, then zeros ->
  - cycle+1: ALUControlE=010, ALUSrcE=1, LoadE=1, RdE=5.
  - cycle+2: RegWriteM=1, ResultSrcM=01, RdM=5.
  - cycle+3: RegWriteW=1, ResultSrcW=01, RdW=5.
- Branch resolution, BeqD=1:
  - ZeroE=1 -> PCSrcE=01; ZeroE=0 -> 00.
  - BneD=1 gives the inverse.
  - JumpD=1 -> 01 irrespective of ZeroE.
  - JalrD=1 -> 10.
- Flush: hold a store {MemWrite=1, Rd=0} on D and pulse FlushE -> next cycle E is all zero (LoadE=0, PCSrcE=00); two cycles later MemWriteM=0. The instruction previously in E still reaches M.
- Reset vs flush: rst=1 and FlushE=1 together, with a valid instruction in E and M -> all stages cleared next cycle, RegWriteM=0, RegWriteW=0.
- Back-to-back: 4 distinct Rd values (1,2,3,4) on consecutive cycles -> RdE, RdM and RdW show each value in sequence with exactly 1-cycle spacing and no duplication or loss.
